// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator back end: frame geometry,
// SPI transmitter state encoding and the frame-word builder.
package dds_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;
  localparam int CTRL_W     = 4;
  localparam int BIT_CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [CTRL_W-1:0] ctrl,
    input logic [DATA_W-1:0] data
  );
    return {ctrl, data};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period generator. The phase idles high, so the first enabled
// half-period doubles as the SYNC_n-to-first-falling-edge setup time.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;
  logic             tick_s;

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("spi_clk_div: CLK_DIV must be >= 1");
    end
  endgenerate

  // last clk of the current half-period
  always_comb begin
    tick_s = en & (cnt_r == CNT_LAST);
  end

  // half-period counter and sclk phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= 1'b1;
    end else if (!en) begin
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= 1'b1;
    end else if (tick_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1'b1);
      phase_r <= phase_r;
    end
  end

  assign phase = phase_r;
  assign rise  = tick_s & ~phase_r;
  assign fall  = tick_s & phase_r;

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one 12-bit DDS sample per frame to a DAC7512/AD5320-class DAC.
// Pin outputs are registered from the state of the previous cycle.
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int                CLK_DIV   = 2,
  parameter int                GAP_CYC   = 4,
  parameter logic [CTRL_W-1:0] CTRL_BITS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic              sclk,
  output logic              sync_n,
  output logic              sdo,
  output logic              busy,
  output logic              frame_done
);

  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS);

  generate
    if (GAP_CYC < 1) begin : g_bad_gap
      $error("dac_spi_tx: GAP_CYC must be >= 1");
    end
  endgenerate

  tx_state_e             state_r;
  tx_state_e             next_state_s;
  logic [FRAME_BITS-1:0] frame_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [GAP_W-1:0]      gap_cnt_r;
  logic                  clk_en_s;
  logic                  phase_s;
  logic                  rise_s;
  logic                  fall_s;
  logic                  accept_s;
  logic                  last_bit_s;
  logic                  sclk_s;
  logic                  sync_n_s;
  logic                  sdo_s;
  logic                  frame_done_s;
  logic                  sclk_r;
  logic                  sync_n_r;
  logic                  sdo_r;
  logic                  din_rdy_r;
  logic                  busy_r;
  logic                  frame_done_r;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en_s),
    .phase (phase_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // handshake and end-of-frame qualifiers
  always_comb begin
    accept_s   = din_vld & din_rdy_r;
    last_bit_s = (bit_cnt_r == BIT_LAST);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; SHIFT ends on the tick closing the 16th high phase
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_SETUP;
        else          next_state_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (fall_s) next_state_s = ST_SHIFT;
        else        next_state_s = ST_SETUP;
      end
      ST_SHIFT: begin
        if (fall_s && last_bit_s) next_state_s = ST_GAP;
        else                      next_state_s = ST_SHIFT;
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) next_state_s = ST_IDLE;
        else                       next_state_s = ST_GAP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode, registered below
  always_comb begin
    clk_en_s     = 1'b0;
    sync_n_s     = 1'b1;
    sclk_s       = 1'b1;
    sdo_s        = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clk_en_s = 1'b0;
      end
      ST_SETUP, ST_SHIFT: begin
        clk_en_s = 1'b1;
        sync_n_s = 1'b0;
        sclk_s   = phase_s;
        sdo_s    = frame_r[FRAME_BITS-1];
      end
      ST_GAP: begin
        frame_done_s = (gap_cnt_r == {GAP_W{1'b0}});
      end
      default: begin
        clk_en_s = 1'b0;
      end
    endcase
  end

  // frame shift register; the 16th rise does not shift so bit 0 holds to the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_r <= {FRAME_BITS{1'b0}};
    end else if (accept_s) begin
      frame_r <= build_frame(CTRL_BITS, din);
    end else if ((state_r == ST_SHIFT) && rise_s && !last_bit_s) begin
      frame_r <= {frame_r[FRAME_BITS-2:0], 1'b0};
    end else begin
      frame_r <= frame_r;
    end
  end

  // bit counter (counts sclk falling edges) and gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= {BIT_CNT_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      if (state_r == ST_IDLE)         bit_cnt_r <= {BIT_CNT_W{1'b0}};
      else if (fall_s && !last_bit_s) bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1'b1);
      else                            bit_cnt_r <= bit_cnt_r;
      if (state_r == ST_GAP) gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
      else                   gap_cnt_r <= {GAP_W{1'b0}};
    end
  end

  // output registers; ready/busy follow the next state so they switch on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_r       <= 1'b1;
      sync_n_r     <= 1'b1;
      sdo_r        <= 1'b0;
      din_rdy_r    <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      sclk_r       <= sclk_s;
      sync_n_r     <= sync_n_s;
      sdo_r        <= sdo_s;
      din_rdy_r    <= (next_state_s == ST_IDLE);
      busy_r       <= (next_state_s != ST_IDLE);
      frame_done_r <= frame_done_s;
    end
  end

  assign sclk       = sclk_r;
  assign sync_n     = sync_n_r;
  assign sdo        = sdo_r;
  assign din_rdy    = din_rdy_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
